// File: rtl/demux4_scatter_ctrl.sv
// demux4_scatter_ctrl: round-robin burst scatter sequencer for the 4-way demux.
// Splits one valid/ready stream across the lanes enabled in lane_mask.
// Each enabled lane receives burst_len beats per visit, for num_rounds full passes.
// The optional per-transfer stall counter output is enabled by defining DEMUX4_SCATTER_STALL_CNT_EN.
module demux4_scatter_ctrl #(
  parameter int WIDTH   = 16,
  parameter int BURST_W = 8,
  parameter int ROUND_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         lane_mask,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [ROUND_W-1:0] num_rounds,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         sel,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic               busy,
`ifdef DEMUX4_SCATTER_STALL_CNT_EN
  output logic               done,
  output logic [31:0]        stall_cnt
`else
  output logic               done
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state;
  logic [BURST_W-1:0] beat_cnt;
  logic [ROUND_W-1:0] round_cnt;
  logic [3:0]         mask_q;
  logic [BURST_W-1:0] burst_q;
  logic [ROUND_W-1:0] rounds_q;

  logic       beat;
  logic       last_beat;
  logic       last_round;
  logic [1:0] next_sel;
  logic       wrap;
  logic       cfg_ok;

  // Lowest enabled lane; caller guarantees a nonzero mask.
  function automatic logic [1:0] lowest_lane(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Next enabled lane strictly after cur, cyclic; returns cur for a one-lane mask.
  function automatic logic [1:0] next_lane(input logic [3:0] m, input logic [1:0] cur);
    logic [1:0] r;
    logic [1:0] cand;
    r = cur;
    for (int k = 3; k >= 1; k--) begin
      cand = cur + 2'(k);
      if (m[cand]) r = cand;
    end
    return r;
  endfunction

  assign busy       = (state == S_XFER);
  assign done       = (state == S_DONE);
  assign out_data   = in_data;
  assign in_ready   = busy && out_ready[sel];
  assign beat       = busy && in_valid && out_ready[sel];
  assign last_beat  = (beat_cnt == burst_q - 1'b1);
  assign last_round = (round_cnt == rounds_q - 1'b1);
  assign next_sel   = next_lane(mask_q, sel);
  assign wrap       = (next_sel <= sel);
  assign cfg_ok     = (lane_mask != 4'd0) && (burst_len != '0) && (num_rounds != '0);

  // Route source valid to the selected lane only; valid never looks at ready.
  always_comb begin
    // NOTE: default first so every path assigns out_valid and no latch is inferred.
    out_valid = 4'd0;
    if (busy) out_valid[sel] = in_valid;
  end

  // Sequencer state, lane select, beat/round counters and latched config.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    if (!rst_n) begin
      state     <= S_IDLE;
      sel       <= 2'd0;
      beat_cnt  <= '0;
      round_cnt <= '0;
      mask_q    <= 4'd0;
      burst_q   <= '0;
      rounds_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              mask_q    <= lane_mask;
              burst_q   <= burst_len;
              rounds_q  <= num_rounds;
              sel       <= lowest_lane(lane_mask);
              beat_cnt  <= '0;
              round_cnt <= '0;
              state     <= S_XFER;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_XFER: begin
          if (beat) begin
            if (!last_beat) begin
              beat_cnt <= beat_cnt + 1'b1;
            end else begin
              beat_cnt <= '0;
              sel      <= next_sel;
              if (wrap) begin
                if (last_round) state <= S_DONE;
                else            round_cnt <= round_cnt + 1'b1;
              end
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DEMUX4_SCATTER_STALL_CNT_EN
  // Saturating count of cycles where the source offers data but the lane refuses it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (state == S_IDLE && start) begin
      stall_cnt <= '0;
    end else if (busy && in_valid && !out_ready[sel] && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_demux4_scatter_ctrl.sv
// Scoreboard bench for demux4_scatter_ctrl: the driver expands each transfer into
// the expected (lane, data) beat list; a negedge monitor pops and compares on every handshake.
module tb_demux4_scatter_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  lane_mask;
  logic [7:0]  burst_len;
  logic [7:0]  num_rounds;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic [1:0]  sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic        busy;
  logic        done;
`ifdef DEMUX4_SCATTER_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  demux4_scatter_ctrl #(.WIDTH(16), .BURST_W(8), .ROUND_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .lane_mask  (lane_mask),
    .burst_len  (burst_len),
    .num_rounds (num_rounds),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .sel        (sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
`ifdef DEMUX4_SCATTER_STALL_CNT_EN
    .done       (done),
    .stall_cnt  (stall_cnt)
`else
    .done       (done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  lane;
    logic [15:0] data;
  } beat_t;

  beat_t       exp_q[$];
  logic [15:0] words[$];
  beat_t       e;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   beats_seen = 0;
  int   done_cnt = 0;
  int   last_hs_cyc = 0;
  int   start_cyc = 0;
  int   ovalid_cycles = 0;
  bit   zero_xfer = 1'b0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: protocol rules every cycle, scoreboard pop on each accepted beat, done timing.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready_rule", 32'(in_ready), 32'(busy ? out_ready[sel] : 1'b0));
      check("out_valid_rule", 32'(out_valid), 32'((busy && in_valid) ? (4'b0001 << sel) : 4'b0000));
      if (out_valid != 4'd0) ovalid_cycles++;
      if ((out_valid & out_ready) != 4'd0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(out_valid), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("beat_lane", 32'(out_valid), 32'(4'b0001 << e.lane));
          check("beat_sel", 32'(sel), 32'(e.lane));
          check("beat_data", 32'(out_data), 32'(e.data));
        end
        beats_seen++;
        last_hs_cyc = cyc;
      end
      if (done) begin
        check("done_single_cycle", 32'(prev_done), 32'(0));
        check("done_timing", 32'(cyc), 32'(zero_xfer ? start_cyc + 1 : last_hs_cyc + 1));
        check("done_all_beats", 32'(exp_q.size()), 32'(0));
        done_cnt++;
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Expand a transfer into its expected beat list: rounds x enabled lanes x burst.
  task automatic build_model(input logic [3:0] m, input logic [7:0] bl, input logic [7:0] nr);
    logic [15:0] w;
    words.delete();
    if (m != 4'd0 && bl != 8'd0 && nr != 8'd0) begin
      for (int r = 0; r < int'(nr); r++)
        for (int l = 0; l < 4; l++)
          if (m[l])
            for (int b = 0; b < int'(bl); b++) begin
              w = 16'($urandom);
              exp_q.push_back('{lane: 2'(l), data: w});
              words.push_back(w);
            end
    end
  endtask

  // Issue start at posedge+1 with the given config; leaves start low one cycle later.
  task automatic issue_start(input logic [3:0] m, input logic [7:0] bl, input logic [7:0] nr);
    @(posedge clk); #1;
    start      = 1'b1;
    lane_mask  = m;
    burst_len  = bl;
    num_rounds = nr;
    zero_xfer  = (m == 4'd0 || bl == 8'd0 || nr == 8'd0);
    start_cyc  = cyc;
    in_valid   = 1'b0;
    @(posedge clk); #1;
    start      = 1'b0;
    lane_mask  = 4'($urandom);
    burst_len  = 8'($urandom);
    num_rounds = 8'($urandom);
  endtask

  // One full transfer with random or shaped valid/ready; bounded by a cycle budget.
  task automatic run_xfer(input logic [3:0] m, input logic [7:0] bl, input logic [7:0] nr,
                          input int vprob, input int rprob, input int stall_after,
                          input int stall_len, input bit spurious);
    int total, base, d0, ov0, n, budget, idx, stall_left;
    build_model(m, bl, nr);
    total      = words.size();
    base       = beats_seen;
    d0         = done_cnt;
    ov0        = ovalid_cycles;
    budget     = 40 * total + 20 + stall_len;
    stall_left = stall_len;
    n          = 0;
    issue_start(m, bl, nr);
    forever begin
      idx      = beats_seen - base;
      in_valid = (idx < total) && ($urandom_range(99) < vprob);
      in_data  = (idx < total) ? words[idx] : 16'($urandom);
      if (stall_left > 0 && idx == stall_after) begin
        out_ready  = 4'd0;
        stall_left--;
      end else if (rprob >= 100) begin
        out_ready = 4'hF;
      end else begin
        for (int l = 0; l < 4; l++) out_ready[l] = ($urandom_range(99) < rprob);
      end
      start      = spurious && ($urandom_range(7) == 0);
      lane_mask  = 4'hF;
      burst_len  = 8'd7;
      num_rounds = 8'd3;
      @(negedge clk); #1;
      n++;
      if (n == 1) check("busy_after_start", 32'(busy), 32'(!zero_xfer));
      if (done_cnt != d0 || n >= budget) break;
      @(posedge clk); #1;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    check("done_seen", 32'(done_cnt - d0), 32'(1));
    check("beat_total", 32'(beats_seen - base), 32'(total));
    if (zero_xfer) check("zero_no_valid", 32'(ovalid_cycles - ov0), 32'(0));
    exp_q.delete();
    @(posedge clk); #1;
    check("idle_after_done", 32'({busy, done}), 32'(0));
  endtask

  // Abort a running transfer with an asynchronous reset after a few beats.
  task automatic reset_mid_xfer();
    int base, d0, n;
    build_model(4'b1111, 8'd2, 8'd1);
    base = beats_seen;
    d0   = done_cnt;
    n    = 0;
    issue_start(4'b1111, 8'd2, 8'd1);
    forever begin
      in_valid  = 1'b1;
      in_data   = words[beats_seen - base];
      out_ready = 4'hF;
      @(negedge clk); #1;
      n++;
      if (beats_seen - base >= 3 || n >= 50) break;
      @(posedge clk); #1;
    end
    check("rst_beats_before_abort", 32'(beats_seen - base), 32'(3));
    rst_n = 1'b0;
    #1;
    check("rst_async_busy", 32'(busy), 32'(0));
    check("rst_async_out_valid", 32'(out_valid), 32'(0));
    check("rst_async_in_ready", 32'(in_ready), 32'(0));
    check("rst_async_sel", 32'(sel), 32'(0));
    check("rst_async_done", 32'(done), 32'(0));
    repeat (3) @(posedge clk);
    #1;
    check("rst_no_done", 32'(done_cnt - d0), 32'(0));
    exp_q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] m;
    logic [7:0] bl, nr;
    rst_n      = 1'b0;
    start      = 1'b0;
    lane_mask  = 4'd0;
    burst_len  = 8'd0;
    num_rounds = 8'd0;
    in_data    = 16'd0;
    in_valid   = 1'b0;
    out_ready  = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_sel", 32'(sel), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_in_ready", 32'(in_ready), 32'(0));
    check("reset_out_valid", 32'(out_valid), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    reset_mid_xfer();
    // Full scatter: sel 0,0,1,1,2,2,3,3.
    run_xfer(4'b1111, 8'd2, 8'd1, 100, 100, -1, 0, 1'b0);
    // Sparse mask with spurious starts while busy.
    run_xfer(4'b1010, 8'd3, 8'd2, 100, 100, -1, 0, 1'b1);
    // Backpressure: lane 0 refuses for 5 cycles after two beats.
    run_xfer(4'b0001, 8'd4, 8'd1, 100, 100, 2, 5, 1'b0);
`ifdef DEMUX4_SCATTER_STALL_CNT_EN
    check("stall_cnt", stall_cnt, 32'd5);
`endif
    // Zero config fields: immediate done, no beats.
    run_xfer(4'b1111, 8'd0, 8'd2, 100, 100, -1, 0, 1'b0);
    run_xfer(4'b0000, 8'd2, 8'd2, 100, 100, -1, 0, 1'b0);
    run_xfer(4'b0110, 8'd2, 8'd0, 100, 100, -1, 0, 1'b0);
    // Counter extremes.
    run_xfer(4'b0100, 8'd255, 8'd1, 100, 100, -1, 0, 1'b0);
    run_xfer(4'b1000, 8'd1, 8'd255, 100, 100, -1, 0, 1'b0);
    // Randomized transfers with random valid/ready and spurious starts.
    for (int t = 0; t < 30; t++) begin
      m  = 4'($urandom_range(15));
      bl = 8'($urandom_range(4));
      nr = 8'($urandom_range(3));
      run_xfer(m, bl, nr, 40 + $urandom_range(60), 40 + $urandom_range(60), -1, 0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux4_scatter_ctrl.md
Name: demux4_scatter_ctrl

Overview:
- Sequencer for the 4-way demultiplexer: scatters a single valid/ready input stream across up to four destination lanes (GLB banks / PE rows), round-robin, in fixed-length bursts.
- Drives the demux select and per-lane valid, back-propagates per-lane ready, and counts beats and rounds.
- Pulses done when the programmed transfer completes.

Parameters:
- WIDTH, 16, data word width; matches demux4 WIDTH.
- BURST_W, 8, width of burst-length and beat counters.
- ROUND_W, 8, width of round counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  one-cycle request to begin a transfer; ignored while busy.
- lane_mask  input  4  enabled lanes; sampled on accepted start.
- burst_len  input  BURST_W  beats per lane visit; sampled on start.
- num_rounds  input  ROUND_W  full passes over the enabled lanes; sampled on start.
- in_data  input  WIDTH  source data.
- in_valid  input  1  source valid.
- in_ready  output  1  source ready.
- out_data  output  WIDTH  data to the demux input; combinational pass-through of in_data.
- sel  output  2  demux select, registered current lane.
- out_valid  output  4  per-lane valid; one-hot or zero.
- out_ready  input  4  per-lane ready.
- busy  output  1  high in XFER.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst_n low, async): state=IDLE, sel=0, beat_cnt=0, round_cnt=0, config registers=0, done=0. busy, in_ready and out_valid are 0.
- States: IDLE, XFER, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - On start with lane_mask!=0, burst_len!=0 and num_rounds!=0: latch the config, set sel to the lowest set bit of lane_mask, clear the counters, go to XFER.
  - On start with any of those three fields zero: go to DONE directly; zero beats are transferred.
- XFER:
  - busy=1, in_ready=out_ready[sel], out_valid[sel]=in_valid, other out_valid bits 0. Zero-cycle latency through the datapath.
  - A beat is transferred when in_valid && out_ready[sel]. Valid must not depend on ready.
  - Beat: if beat_cnt!=burst_len-1, increment beat_cnt. Otherwise:
    - clear beat_cnt;
    - set sel to the next set bit of the latched mask strictly after sel, searching cyclically 0..3;
    - the advance wraps when the new sel <= old sel, which includes a single-lane mask;
    - on wrap: if round_cnt==num_rounds-1, go to DONE; else increment round_cnt.
  - No beat in a cycle: state held.
  - start is ignored. The latched config is unaffected by input changes.
- DONE: done=1 for exactly one cycle, in_ready=0, then go to IDLE. sel keeps its last value.
- Total beats per transfer = popcount(mask) * burst_len * num_rounds.
- Counter comparisons are full-width unsigned. burst_len=2^BURST_W-1 is legal; no overflow occurs because the counter clears at burst_len-1.
- start asserted in the DONE cycle is ignored; it is accepted only in IDLE.
- Reset asserted mid-XFER aborts immediately: no done pulse, and outputs return to reset values asynchronously.

Optional Feature:
- Macro DEMUX4_SCATTER_STALL_CNT_EN.
- Defined: adds output stall_cnt [31:0]. It increments, saturating, every XFER cycle with in_valid && !out_ready[sel], clears on accepted start and on reset, and holds otherwise.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset mid-transfer: mask=4'b1111, burst_len=2, num_rounds=1, start; assert rst_n=0 after 3 beats -> all outputs zero at once, no done pulse; a later start runs normally.
- Full scatter: mask=4'b1111, burst_len=2, num_rounds=1, all ready, in_valid constant -> 8 beats, sel sequence 0,0,1,1,2,2,3,3, done pulse the cycle after the 8th beat.
- Sparse mask: mask=4'b1010, burst_len=3, num_rounds=2 -> sel 1,1,1,3,3,3,1,1,1,3,3,3, 12 beats, then done.
- Backpressure: mask=4'b0001, burst_len=4, out_ready[0] low for 5 cycles mid-burst -> in_ready low, beat_cnt held, no data loss; with macro defined, stall_cnt=5.
- Zero config: start with burst_len=0 -> done pulse one cycle later, no out_valid ever asserted. Second start while busy -> ignored, beat total unchanged.
